lane_queue_ctrl: RTL



---
 rtl/lane_queue_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/lane_queue_ctrl.sv
// ---------------------------------------------------------------------------
// lane_queue_ctrl
//   Per-lane car queue controller. Arrival pulses fill an occupancy counter.
//   While the lane light is green, a startup-delay / flow-interval FSM meters
//   departures. The controller tracks how long the head car has waited on red
//   and raises a green request for the light-sequencing FSM.
//
// Ports
//   traffic_clk      in   traffic clock
//   reset            in   asynchronous active-high reset
//   add_Car          in   arrival pulse, one car per cycle high
//   lane_Green       in   this lane's light is green
//   car_Count        out  [CNT_W]  cars queued
//   queue_Empty      out  car_Count == 0
//   queue_Full       out  car_Count == MAX_CARS
//   car_Departed     out  a car leaves this cycle
//   wait_Cycles      out  [WAIT_W] cycles the head car has waited on red
//   green_Request    out  request green for this lane
//   overflow_Sticky  out  an arrival was dropped since reset
// ---------------------------------------------------------------------------
module lane_queue_ctrl #(
  parameter int CNT_W         = 4,
  parameter int MAX_CARS      = 15,
  parameter int START_DELAY   = 3,
  parameter int DEPART_CYCLES = 2,
  parameter int REQ_THRESHOLD = 4,
  parameter int WAIT_W        = 8,
  parameter int MAX_WAIT      = 20
) (
  input  logic              traffic_clk,
  input  logic              reset,
  input  logic              add_Car,
  input  logic              lane_Green,
  output logic [CNT_W-1:0]  car_Count,
  output logic              queue_Empty,
  output logic              queue_Full,
  output logic              car_Departed,
  output logic [WAIT_W-1:0] wait_Cycles,
  output logic              green_Request,
  output logic              overflow_Sticky
);

  // The timer only ever holds reload values START_DELAY-1 / DEPART_CYCLES-1.
  localparam int TMR_MAX = (START_DELAY > DEPART_CYCLES) ? START_DELAY : DEPART_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0]  START_LOAD  = TMR_W'(START_DELAY - 1);
  localparam logic [TMR_W-1:0]  DEPART_LOAD = TMR_W'(DEPART_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = CNT_W'(MAX_CARS);
  localparam logic [CNT_W-1:0]  REQ_LVL     = CNT_W'(REQ_THRESHOLD);
  localparam logic [WAIT_W-1:0] WAIT_LVL    = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    STARTUP = 2'd1,
    FLOWING = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [WAIT_W-1:0]  wait_nxt;
  logic               ovf_set;

  // Saturating increment for the head-car wait counter.
  function automatic logic [WAIT_W-1:0] wait_sat_inc(input logic [WAIT_W-1:0] v);
    return (&v) ? v : v + WAIT_W'(1);
  endfunction

  // FSM state register
  always_ff @(posedge traffic_clk or posedge reset) begin
    if (reset) begin
      state <= STOPPED;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    unique case (state)
      STOPPED: begin
        if (lane_Green) begin
          state_nxt = STARTUP;
          timer_nxt = START_LOAD;
        end
      end
      STARTUP: begin
        if (!lane_Green) begin
          state_nxt = STOPPED;
        end else if (timer == '0) begin
          state_nxt = FLOWING;
          timer_nxt = DEPART_LOAD;
        end else begin
          timer_nxt = timer - TMR_W'(1);
        end
      end
      FLOWING: begin
        if (!lane_Green) begin
          state_nxt = STOPPED;
        end else if (timer == '0) begin
          // An empty lane parks at timer 0 so the next arrival leaves at once.
          if (car_Count != '0) timer_nxt = DEPART_LOAD;
        end else begin
          timer_nxt = timer - TMR_W'(1);
        end
      end
      default: begin
        state_nxt = STOPPED;
        timer_nxt = '0;
      end
    endcase
  end

  // FSM outputs; departure is gated by lane_Green so a green drop suppresses it
  always_comb begin
    car_Departed  = lane_Green && (state != STOPPED) && (timer == '0) && (car_Count != '0);
    queue_Empty   = (car_Count == '0);
    queue_Full    = (car_Count == CNT_MAX);
    green_Request = !lane_Green && ((car_Count >= REQ_LVL) || (wait_Cycles >= WAIT_LVL));
  end

  // Queue and wait-timer next values. Simultaneous arrival and departure
  // cancel, which is why a full queue does not overflow in that case.
  always_comb begin
    cnt_nxt = car_Count;
    ovf_set = 1'b0;
    if (add_Car && !car_Departed) begin
      if (car_Count < CNT_MAX) cnt_nxt = car_Count + CNT_W'(1);
      else                     ovf_set = 1'b1;
    end else if (!add_Car && car_Departed) begin
      cnt_nxt = car_Count - CNT_W'(1);
    end

    if (lane_Green || (cnt_nxt == '0)) wait_nxt = '0;
    else                               wait_nxt = wait_sat_inc(wait_Cycles);
  end

  // Queue / wait registers
  always_ff @(posedge traffic_clk or posedge reset) begin
    if (reset) begin
      car_Count       <= '0;
      wait_Cycles     <= '0;
      overflow_Sticky <= 1'b0;
    end else begin
      car_Count   <= cnt_nxt;
      wait_Cycles <= wait_nxt;
      if (ovf_set) overflow_Sticky <= 1'b1;
    end
  end

endmodule
